// File: rtl/tank_level_emulator.sv
// Tank plant model: integrates pump fill and consumer drain into a saturating
// level, decodes it to a thermometer sensor bus with stuck-at-0 fault forcing.
module tank_level_emulator #(
   parameter int LEVEL_W    = 8,
   parameter int FILL_DIV   = 4,
   parameter int DRAIN_DIV  = 8,
   parameter int TH_LOW     = 32,
   parameter int TH_MID     = 128,
   parameter int TH_HIGH    = 224,
   parameter int LEVEL_INIT = 0
) (
   input  logic               ck,
   input  logic               rst_i,
   input  logic               bomba_i,
   input  logic               drain_en_i,
   input  logic [2:0]         sensor_fault_i,
   output logic [2:0]         sensores_o,
   output logic [LEVEL_W-1:0] level_o,
   output logic               empty_o,
   output logic               overflow_o
);

   localparam int FILL_W  = (FILL_DIV  > 1) ? $clog2(FILL_DIV)  : 1;
   localparam int DRAIN_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

   localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(FILL_DIV - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_DIV - 1);
   localparam logic [LEVEL_W-1:0] LEVEL_MAX  = '1;
   localparam logic [LEVEL_W-1:0] LVL_INIT   = LEVEL_W'(LEVEL_INIT);
   localparam logic [LEVEL_W-1:0] LVL_LOW    = LEVEL_W'(TH_LOW);
   localparam logic [LEVEL_W-1:0] LVL_MID    = LEVEL_W'(TH_MID);
   localparam logic [LEVEL_W-1:0] LVL_HIGH   = LEVEL_W'(TH_HIGH);

   function automatic logic [2:0] decode(input logic [LEVEL_W-1:0] lvl);
      return {lvl >= LVL_HIGH, lvl >= LVL_MID, lvl >= LVL_LOW};
   endfunction

   logic [FILL_W-1:0]  fill_cnt;
   logic [DRAIN_W-1:0] drain_cnt;
   logic               fill_tick;
   logic               drain_tick;
   logic [LEVEL_W-1:0] level_nxt;
   logic               ovf_set;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; a missing default infers a latch.
   always_comb begin
      fill_tick  = bomba_i    && (fill_cnt  == FILL_LAST);
      drain_tick = drain_en_i && (drain_cnt == DRAIN_LAST);
      level_nxt  = level_o;
      ovf_set    = 1'b0;
      // Coincident ticks cancel, even at either saturation limit.
      unique case ({fill_tick, drain_tick})
         2'b10: begin
            if (level_o == LEVEL_MAX) ovf_set   = 1'b1;
            else                      level_nxt = level_o + LEVEL_W'(1);
         end
         2'b01: begin
            if (level_o != '0) level_nxt = level_o - LEVEL_W'(1);
         end
         default: level_nxt = level_o;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create order races.
   always_ff @(posedge ck) begin
      if (rst_i) begin
         fill_cnt   <= '0;
         drain_cnt  <= '0;
         level_o    <= LVL_INIT;
         empty_o    <= (LVL_INIT == '0);
         overflow_o <= 1'b0;
         sensores_o <= decode(LVL_INIT);
      end else begin
         fill_cnt   <= (!bomba_i    || fill_tick)  ? '0 : fill_cnt  + FILL_W'(1);
         drain_cnt  <= (!drain_en_i || drain_tick) ? '0 : drain_cnt + DRAIN_W'(1);
         level_o    <= level_nxt;
         empty_o    <= (level_nxt == '0);
         overflow_o <= overflow_o | ovf_set;
         // Decoded from the current registered level, giving one cycle of lag.
         sensores_o <= decode(level_o) & ~sensor_fault_i;
      end
   end

endmodule

// File: tb/tb_tank_level_emulator.sv
// Directed bench for tank_level_emulator: cycle-by-cycle comparison against an
// arithmetic plant model, plus literal expectations at the key scenario points.
module tb_tank_level_emulator;

   localparam int LEVEL_MAX = 255;
   localparam int FILL_DIV  = 4;
   localparam int DRAIN_DIV = 8;

   logic       ck = 1'b0;
   logic       rst_i = 1'b1;
   logic       bomba_i = 1'b0;
   logic       drain_en_i = 1'b0;
   logic [2:0] sensor_fault_i = 3'b000;
   logic [2:0] sensores_o;
   logic [7:0] level_o;
   logic       empty_o;
   logic       overflow_o;

   int total = 0;
   int bad   = 0;

   // Model state: level as an integer, run lengths of consecutive enabled edges.
   int m_level = 0;
   int m_fill_run = 0;
   int m_drain_run = 0;
   int m_sens = 0;
   int m_ovf = 0;

   tank_level_emulator dut (
      .ck             (ck),
      .rst_i          (rst_i),
      .bomba_i        (bomba_i),
      .drain_en_i     (drain_en_i),
      .sensor_fault_i (sensor_fault_i),
      .sensores_o     (sensores_o),
      .level_o        (level_o),
      .empty_o        (empty_o),
      .overflow_o     (overflow_o)
   );

   always #5 ck = ~ck;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int thermo(input int lvl);
      return ((lvl >= 224) ? 4 : 0) | ((lvl >= 128) ? 2 : 0) | ((lvl >= 32) ? 1 : 0);
   endfunction

   task automatic model_edge(input bit r, input bit b, input bit d, input int f);
      bit ft;
      bit dt;
      if (r) begin
         m_level = 0; m_fill_run = 0; m_drain_run = 0; m_sens = 0; m_ovf = 0;
      end else begin
         m_fill_run  = b ? m_fill_run + 1 : 0;
         m_drain_run = d ? m_drain_run + 1 : 0;
         ft = b && (m_fill_run % FILL_DIV == 0);
         dt = d && (m_drain_run % DRAIN_DIV == 0);
         m_sens = thermo(m_level) & ~f & 7;
         if (ft && !dt) begin
            if (m_level == LEVEL_MAX) m_ovf = 1;
            else                      m_level++;
         end else if (dt && !ft && m_level > 0) begin
            m_level--;
         end
      end
   endtask

   task automatic step(input bit r, input bit b, input bit d, input logic [2:0] f);
      rst_i = r; bomba_i = b; drain_en_i = d; sensor_fault_i = f;
      @(posedge ck);
      model_edge(r, b, d, int'(f));
      #1;
      check("level", int'(level_o), m_level);
      check("empty", int'(empty_o), (m_level == 0) ? 1 : 0);
      check("sensores", int'(sensores_o), m_sens);
      check("overflow", int'(overflow_o), m_ovf);
   endtask

   task automatic run(input int n, input bit b, input bit d, input logic [2:0] f);
      for (int i = 0; i < n; i++) step(1'b0, b, d, f);
   endtask

   initial begin
      // Reset with random other inputs, twice.
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)));
         check("rst_level", int'(level_o), 0);
         check("rst_sens", int'(sensores_o), 0);
         check("rst_empty", int'(empty_o), 1);
         check("rst_ovf", int'(overflow_o), 0);
      end

      // Fill from empty.
      run(3, 1'b1, 1'b0, 3'b000);
      check("fill_e3_level", int'(level_o), 0);
      run(1, 1'b1, 1'b0, 3'b000);
      check("fill_e4_level", int'(level_o), 1);
      check("fill_e4_empty", int'(empty_o), 0);
      run(124, 1'b1, 1'b0, 3'b000);
      check("fill_e128_level", int'(level_o), 32);
      check("fill_e128_sens", int'(sensores_o), 0);
      run(1, 1'b1, 1'b0, 3'b000);
      check("fill_e129_sens", int'(sensores_o), 1);

      // Saturation at full and sticky overflow.
      run(891, 1'b1, 1'b0, 3'b000);
      check("full_level", int'(level_o), 255);
      check("full_ovf_pre", int'(overflow_o), 0);
      run(4, 1'b1, 1'b0, 3'b000);
      check("full_level_sat", int'(level_o), 255);
      check("full_ovf_set", int'(overflow_o), 1);
      run(5, 1'b0, 1'b0, 3'b000);
      check("full_ovf_sticky", int'(overflow_o), 1);
      check("full_sens", int'(sensores_o), 7);
      step(1'b1, 1'b0, 1'b0, 3'b000);
      check("ovf_cleared", int'(overflow_o), 0);

      // Coincident fill and drain from level 100.
      run(400, 1'b1, 1'b0, 3'b000);
      check("lvl100", int'(level_o), 100);
      run(1, 1'b0, 1'b0, 3'b000);
      run(4, 1'b1, 1'b1, 3'b000);
      check("both_e4", int'(level_o), 101);
      run(4, 1'b1, 1'b1, 3'b000);
      check("both_e8", int'(level_o), 101);
      run(8, 1'b1, 1'b1, 3'b000);
      check("both_e16", int'(level_o), 102);

      // Drain from 1 to empty and hold.
      run(1, 1'b0, 1'b0, 3'b000);
      run(808, 1'b0, 1'b1, 3'b000);
      check("lvl1", int'(level_o), 1);
      run(1, 1'b0, 1'b0, 3'b000);
      run(7, 1'b0, 1'b1, 3'b000);
      check("drain_e7_level", int'(level_o), 1);
      check("drain_e7_empty", int'(empty_o), 0);
      run(1, 1'b0, 1'b1, 3'b000);
      check("drain_e8_level", int'(level_o), 0);
      check("drain_e8_empty", int'(empty_o), 1);
      run(24, 1'b0, 1'b1, 3'b000);
      check("drain_e32_level", int'(level_o), 0);
      check("drain_e32_ovf", int'(overflow_o), 0);

      // Sensor fault at level 240, then reset mid-step.
      step(1'b1, 1'b0, 1'b0, 3'b000);
      run(960, 1'b1, 1'b0, 3'b000);
      check("lvl240", int'(level_o), 240);
      run(1, 1'b0, 1'b0, 3'b000);
      check("sens240", int'(sensores_o), 7);
      run(1, 1'b0, 1'b0, 3'b100);
      check("sens_fault", int'(sensores_o), 3);
      run(2, 1'b1, 1'b0, 3'b100);
      step(1'b1, 1'b1, 1'b0, 3'b100);
      check("midstep_rst_level", int'(level_o), 0);
      check("midstep_rst_sens", int'(sensores_o), 0);
      run(3, 1'b1, 1'b0, 3'b000);
      check("post_rst_e3", int'(level_o), 0);
      run(1, 1'b1, 1'b0, 3'b000);
      check("post_rst_e4", int'(level_o), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
